apb_rx_controller: RTL and testbench

APB master sequencer for the UART receiver's APB register slave. On a start pulse it programs bit period and data size over APB, then polls the status register. When a byte is pending, it reads the error and data-buffer registers and delivers the byte to a downstream consumer through a one-entry valid/ready buffer. It sits between system control logic and the receiver's register interface and replaces software polling.

---
 rtl/apb_rx_controller.sv | 184 ++++++++++++++++++
 tb/tb_apb_rx_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rx_controller.sv
// APB master sequencer for the UART receiver register slave: programs bit period
// and data size, polls status, and hands received bytes to a one-entry valid/ready buffer.
module apb_rx_controller #(
   parameter int POLL_GAP = 4
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        cfg_start,
   input  logic        cfg_stop,
   input  logic [13:0] cfg_bit_period,
   input  logic [3:0]  cfg_data_size,
   input  logic        clr_err,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [2:0]  paddr,
   output logic [7:0]  pwdata,
   input  logic [7:0]  prdata,
   input  logic        pslverr,
   output logic [7:0]  rx_byte,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        cfg_done,
   output logic        busy,
   output logic        err_framing,
   output logic        err_overrun,
   output logic        err_slv
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR_BP0, ST_WR_BP1, ST_WR_DS, ST_RD_STAT, ST_RD_ERR, ST_RD_DATA, ST_GAP
   } state_t;

   localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);
   localparam logic [7:0] GAP_MAX  = 8'(POLL_GAP);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [13:0] bp_r;
   logic [13:0] bp_src_s;
   logic [3:0]  ds_r;
   logic [3:0]  ds_src_s;
   logic [7:0]  gap_cnt_r;
   logic        discard_r;
   logic        access_end_s;
   logic        new_state_s;
   logic        rx_free_s;
   logic [2:0]  addr_nxt_s;
   logic [7:0]  wdata_nxt_s;
   logic        set_framing_s;
   logic        set_overrun_s;
   logic        set_slv_s;

   function automatic logic is_xfer(input state_t s);
      return (s != ST_IDLE) && (s != ST_GAP);
   endfunction

   function automatic logic is_write(input state_t s);
      return (s == ST_WR_BP0) || (s == ST_WR_BP1) || (s == ST_WR_DS);
   endfunction

   // Next-state decode; every transfer state leaves only at the end of its access cycle
   always_comb begin
      access_end_s = psel & penable;
      rx_free_s    = ~rx_valid | rx_ready;
      bp_src_s     = (state_r == ST_IDLE) ? cfg_bit_period : bp_r;
      ds_src_s     = (state_r == ST_IDLE) ? cfg_data_size : ds_r;
      state_nxt_s  = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cfg_start) begin
               state_nxt_s = ST_WR_BP0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (cfg_stop) begin
               state_nxt_s = ST_IDLE;
            end else if ((gap_cnt_r >= GAP_LAST) && rx_free_s) begin
               state_nxt_s = ST_RD_STAT;
            end else begin
               state_nxt_s = ST_GAP;
            end
         end
         default: begin
            if (!access_end_s) begin
               state_nxt_s = state_r;
            end else if (pslverr && is_write(state_r)) begin
               state_nxt_s = ST_IDLE;
            end else if (cfg_stop) begin
               state_nxt_s = ST_IDLE;
            end else if (pslverr) begin
               state_nxt_s = ST_GAP;
            end else begin
               case (state_r)
                  ST_WR_BP0:  state_nxt_s = ST_WR_BP1;
                  ST_WR_BP1:  state_nxt_s = ST_WR_DS;
                  ST_WR_DS:   state_nxt_s = ST_RD_STAT;
                  ST_RD_STAT: state_nxt_s = prdata[0] ? ST_RD_ERR : ST_GAP;
                  ST_RD_ERR:  state_nxt_s = ST_RD_DATA;
                  ST_RD_DATA: state_nxt_s = ST_GAP;
                  default:    state_nxt_s = ST_IDLE;
               endcase
            end
         end
      endcase
      new_state_s = (state_nxt_s != state_r);

      case (state_nxt_s)
         ST_WR_BP0:  begin addr_nxt_s = 3'd2; wdata_nxt_s = bp_src_s[7:0]; end
         ST_WR_BP1:  begin addr_nxt_s = 3'd3; wdata_nxt_s = {2'b00, bp_src_s[13:8]}; end
         ST_WR_DS:   begin addr_nxt_s = 3'd4; wdata_nxt_s = {4'b0000, ds_src_s}; end
         ST_RD_STAT: begin addr_nxt_s = 3'd0; wdata_nxt_s = 8'h00; end
         ST_RD_ERR:  begin addr_nxt_s = 3'd1; wdata_nxt_s = 8'h00; end
         ST_RD_DATA: begin addr_nxt_s = 3'd6; wdata_nxt_s = 8'h00; end
         default:    begin addr_nxt_s = 3'd0; wdata_nxt_s = 8'h00; end
      endcase

      set_slv_s     = access_end_s & pslverr;
      set_framing_s = access_end_s & ~pslverr & (state_r == ST_RD_ERR) & (prdata == 8'h01);
      set_overrun_s = access_end_s & ~pslverr & (state_r == ST_RD_ERR) & (prdata == 8'h02);
   end

   // State register, registered APB/status outputs, gap counter and receive buffer
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r     <= ST_IDLE;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= 3'd0;
         pwdata      <= 8'h00;
         busy        <= 1'b0;
         cfg_done    <= 1'b0;
         bp_r        <= 14'd0;
         ds_r        <= 4'd0;
         gap_cnt_r   <= 8'd0;
         discard_r   <= 1'b0;
         rx_valid    <= 1'b0;
         rx_byte     <= 8'h00;
         err_framing <= 1'b0;
         err_overrun <= 1'b0;
         err_slv     <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         // staying in a transfer state only happens on setup -> access
         psel     <= is_xfer(state_nxt_s);
         penable  <= is_xfer(state_nxt_s) & ~new_state_s;
         pwrite   <= is_write(state_nxt_s);
         paddr    <= addr_nxt_s;
         pwdata   <= wdata_nxt_s;
         busy     <= (state_nxt_s != ST_IDLE);
         cfg_done <= access_end_s & ~pslverr & (state_r == ST_WR_DS);

         if ((state_r == ST_IDLE) && cfg_start) begin
            bp_r <= cfg_bit_period;
            ds_r <= cfg_data_size;
         end

         if (new_state_s && (state_nxt_s == ST_GAP)) begin
            gap_cnt_r <= 8'd0;
         end else if ((state_r == ST_GAP) && (gap_cnt_r < GAP_MAX)) begin
            gap_cnt_r <= gap_cnt_r + 8'd1;
         end

         if (access_end_s && (state_r == ST_RD_ERR)) begin
            discard_r <= ~pslverr & (prdata == 8'h01);
         end

         if (access_end_s && !pslverr && (state_r == ST_RD_DATA) && !discard_r) begin
            rx_valid <= 1'b1;
            rx_byte  <= prdata;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         err_framing <= set_framing_s | (err_framing & ~clr_err);
         err_overrun <= set_overrun_s | (err_overrun & ~clr_err);
         err_slv     <= set_slv_s | (err_slv & ~clr_err);
      end
   end

endmodule

// File: tb/tb_apb_rx_controller.sv
// Scoreboard bench for apb_rx_controller: directed scenarios push expected APB
// accesses, cfg_done pulses and byte handshakes; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_apb_rx_controller;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        cfg_start, cfg_stop, clr_err, rx_ready;
   logic [13:0] cfg_bit_period;
   logic [3:0]  cfg_data_size;
   logic        psel, penable, pwrite, pslverr;
   logic [2:0]  paddr;
   logic [7:0]  pwdata, prdata, rx_byte;
   logic        rx_valid, cfg_done, busy, err_framing, err_overrun, err_slv;

   logic [7:0]  r_stat, r_err, r_data;
   logic        slv_en;
   logic [2:0]  slv_addr;

   typedef struct {
      int         cyc;
      logic [11:0] val;
   } exp_t;

   exp_t acc_q[$];
   exp_t done_q[$];
   exp_t rx_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int base  = 0;

   apb_rx_controller #(.POLL_GAP(4)) dut (
      .clk(clk), .n_rst(n_rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_bit_period(cfg_bit_period), .cfg_data_size(cfg_data_size), .clr_err(clr_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pslverr(pslverr), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .cfg_done(cfg_done), .busy(busy), .err_framing(err_framing),
      .err_overrun(err_overrun), .err_slv(err_slv)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Register slave model answering during the access cycle
   always_comb begin
      prdata  = 8'h00;
      pslverr = 1'b0;
      if (psel && penable) begin
         case (paddr)
            3'd0:    prdata = r_stat;
            3'd1:    prdata = r_err;
            3'd6:    prdata = r_data;
            default: prdata = 8'h00;
         endcase
         pslverr = slv_en && (paddr == slv_addr);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc - base);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got unexpected event 0x%0h, expected none (cycle %0d)", name, act, cyc - base);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an event
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (psel && penable) begin
         if (acc_q.size() == 0) begin
            unexpected("apb_access", 32'({pwrite, paddr, pwdata}));
         end else begin
            e = acc_q.pop_front();
            check("apb_access_cycle", 32'(cyc - base), 32'(e.cyc - base));
            check("apb_access_value", 32'({pwrite, paddr, pwdata}), 32'(e.val));
         end
      end
      if (cfg_done) begin
         if (done_q.size() == 0) begin
            unexpected("cfg_done", 32'(1));
         end else begin
            e = done_q.pop_front();
            check("cfg_done_cycle", 32'(cyc - base), 32'(e.cyc - base));
         end
      end
      if (rx_valid && rx_ready) begin
         if (rx_q.size() == 0) begin
            unexpected("rx_handshake", 32'(rx_byte));
         end else begin
            e = rx_q.pop_front();
            check("rx_handshake_cycle", 32'(cyc - base), 32'(e.cyc - base));
            check("rx_byte", 32'(rx_byte), 32'(e.val));
         end
      end
   end

   task automatic to_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic push_acc(input int c, input logic w, input logic [2:0] a, input logic [7:0] d);
      acc_q.push_back('{cyc: c, val: {w, a, d}});
   endtask

   task automatic push_rx(input int c, input logic [7:0] b);
      rx_q.push_back('{cyc: c, val: {4'h0, b}});
   endtask

   // Issues cfg_start in the current cycle (cycle 0) and queues nwr config writes
   task automatic start_cfg(input logic [13:0] bp, input logic [3:0] ds, input int nwr);
      base           = cyc;
      cfg_bit_period = bp;
      cfg_data_size  = ds;
      cfg_start      = 1'b1;
      if (nwr >= 1) push_acc(base + 2, 1'b1, 3'd2, bp[7:0]);
      if (nwr >= 2) push_acc(base + 4, 1'b1, 3'd3, {2'b00, bp[13:8]});
      if (nwr >= 3) begin
         push_acc(base + 6, 1'b1, 3'd4, {4'h0, ds});
         done_q.push_back('{cyc: base + 7, val: 12'h001});
      end
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      n_rst = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; clr_err = 1'b0; rx_ready = 1'b1;
      cfg_bit_period = 14'd0; cfg_data_size = 4'd0;
      r_stat = 8'h00; r_err = 8'h00; r_data = 8'h00; slv_en = 1'b0; slv_addr = 3'd0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({psel, penable, pwrite, paddr, pwdata, rx_byte, rx_valid,
                                  cfg_done, busy, err_framing, err_overrun, err_slv}), 32'd0);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_reset", 32'({psel, busy}), 32'd0);

      // Config writes, then idle polls with a 4-cycle gap, stopped in GAP
      r_stat = 8'h00;
      start_cfg(14'h1A2B, 4'h8, 3);
      push_acc(base + 8, 1'b0, 3'd0, 8'h00);
      push_acc(base + 14, 1'b0, 3'd0, 8'h00);
      to_cyc(base + 10);
      check("busy_in_gap", 32'(busy), 32'd1);
      check("gap_bus_quiet", 32'({psel, paddr, pwdata}), 32'd0);
      to_cyc(base + 16);
      cfg_stop = 1'b1;
      @(negedge clk);
      cfg_stop = 1'b0;
      check("idle_after_stop", 32'({busy, psel}), 32'd0);
      repeat (3) @(negedge clk);

      // Byte path with the consumer stalled for 10 cycles
      rx_ready = 1'b0; r_stat = 8'h01; r_err = 8'h00; r_data = 8'hA5;
      start_cfg(14'h0005, 4'h7, 3);
      push_acc(base + 8, 1'b0, 3'd0, 8'h00);
      push_acc(base + 10, 1'b0, 3'd1, 8'h00);
      push_acc(base + 12, 1'b0, 3'd6, 8'h00);
      push_acc(base + 25, 1'b0, 3'd0, 8'h00);
      push_rx(base + 23, 8'hA5);
      to_cyc(base + 13);
      check("rx_valid_first", 32'({rx_valid, rx_byte}), 32'h1A5);
      n = 0;
      for (int k = 13; k <= 22; k++) begin
         to_cyc(base + k);
         if (psel) n++;
      end
      check("no_poll_while_full", 32'(n), 32'd0);
      to_cyc(base + 23);
      rx_ready = 1'b1;
      r_stat   = 8'h00;
      to_cyc(base + 27);
      cfg_stop = 1'b1;
      @(negedge clk);
      cfg_stop = 1'b0;
      repeat (3) @(negedge clk);

      // Framing error discards the byte; overrun still delivers it; clr_err clears both
      r_stat = 8'h01; r_err = 8'h01; r_data = 8'h3C;
      start_cfg(14'h0100, 4'h5, 3);
      push_acc(base + 8, 1'b0, 3'd0, 8'h00);
      push_acc(base + 10, 1'b0, 3'd1, 8'h00);
      push_acc(base + 12, 1'b0, 3'd6, 8'h00);
      push_acc(base + 18, 1'b0, 3'd0, 8'h00);
      push_acc(base + 20, 1'b0, 3'd1, 8'h00);
      push_acc(base + 22, 1'b0, 3'd6, 8'h00);
      push_acc(base + 28, 1'b0, 3'd0, 8'h00);
      push_rx(base + 23, 8'h5A);
      to_cyc(base + 11);
      check("err_framing_set", 32'({err_framing, err_overrun}), 32'h2);
      to_cyc(base + 14);
      check("framing_byte_dropped", 32'(rx_valid), 32'd0);
      r_err  = 8'h02;
      r_data = 8'h5A;
      to_cyc(base + 21);
      check("err_overrun_set", 32'({err_framing, err_overrun}), 32'h3);
      to_cyc(base + 24);
      r_stat = 8'h00;
      to_cyc(base + 30);
      cfg_stop = 1'b1;
      @(negedge clk);
      cfg_stop = 1'b0;
      clr_err  = 1'b1;
      @(negedge clk);
      clr_err  = 1'b0;
      check("clr_err_clears", 32'({err_framing, err_overrun, err_slv}), 32'd0);
      repeat (2) @(negedge clk);

      // Slave error on the second config write aborts configuration
      slv_en = 1'b1; slv_addr = 3'd3;
      start_cfg(14'h2222, 4'h3, 2);
      to_cyc(base + 5);
      check("slverr_abort", 32'({err_slv, busy, psel}), 32'h4);
      slv_en = 1'b0;
      to_cyc(base + 10);

      // cfg_stop during RD_DATA setup lets the access complete before IDLE
      r_stat = 8'h01; r_err = 8'h00; r_data = 8'h77;
      start_cfg(14'h3FFF, 4'hF, 3);
      push_acc(base + 8, 1'b0, 3'd0, 8'h00);
      push_acc(base + 10, 1'b0, 3'd1, 8'h00);
      push_acc(base + 12, 1'b0, 3'd6, 8'h00);
      push_rx(base + 13, 8'h77);
      to_cyc(base + 11);
      cfg_stop = 1'b1;
      to_cyc(base + 13);
      check("stop_after_access", 32'({busy, psel, err_slv}), 32'h1);
      cfg_stop = 1'b0;
      to_cyc(base + 16);

      // Asynchronous reset in the middle of an access
      start_cfg(14'h0ABC, 4'h2, 1);
      to_cyc(base + 2);
      #2;
      n_rst = 1'b0;
      #1;
      check("async_reset_outputs", 32'({psel, penable, pwrite, paddr, pwdata, busy,
                                        rx_valid, cfg_done, err_slv}), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_async_reset", 32'({psel, busy}), 32'd0);

      check("acc_queue_drained", 32'(acc_q.size()), 32'd0);
      check("done_queue_drained", 32'(done_q.size()), 32'd0);
      check("rx_queue_drained", 32'(rx_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
